// File: rtl/ar_fifo_pkg.sv
// ---------------------------------------------------------------------------
// ar_fifo_pkg
//   Shared sizing helpers for the SRL-based FIFO family.
//
//   srl_depth(l2depth) : number of entries in the shift-register array
//   fifo_cap(l2depth)  : total capacity, SRL entries plus the output D register
//   cnt_w(l2depth)     : width of an occupancy counter that can hold 0..CAP
//   thr_clamp(...)     : forces a threshold parameter into its legal range so a
//                        bad override degrades to the nearest legal value
//                        instead of producing a flag that can never toggle
//
//   No ports (package).
// ---------------------------------------------------------------------------
package ar_fifo_pkg;

    function automatic int srl_depth(input int l2depth);
        return 1 << l2depth;
    endfunction

    function automatic int fifo_cap(input int l2depth);
        return (1 << l2depth) + 1;
    endfunction

    // CAP = 2**l2depth + 1 always fits in l2depth+1 bits.
    function automatic int cnt_w(input int l2depth);
        return l2depth + 1;
    endfunction

    function automatic int thr_clamp(input int thr, input int lo, input int hi);
        if (thr < lo) begin
            return lo;
        end
        if (thr > hi) begin
            return hi;
        end
        return thr;
    endfunction

endpackage

// File: rtl/ar_srl_shift.sv
// ---------------------------------------------------------------------------
// ar_srl_shift
//   Reset-free shift-register array with an addressable read port. Written so
//   that synthesis maps it onto SRL primitives: no reset, a single shift
//   enable, and a combinational read mux selected by rd_addr.
//
//   Entry 0 always holds the most recent write; older entries move up by one
//   on every shift, so the oldest live entry sits at index (occupancy-1).
//
//   Ports
//     CLK       in   1         clock, posedge
//     shift_en  in   1         shift d_in into entry 0
//     d_in      in   width     write data
//     rd_addr   in   l2depth   entry to read
//     d_out     out  width     dat[rd_addr], combinational
// ---------------------------------------------------------------------------
module ar_srl_shift
    import ar_fifo_pkg::*;
#(
    parameter int width   = 128,
    parameter int l2depth = 5
) (
    input  logic               CLK,
    input  logic               shift_en,
    input  logic [width-1:0]   d_in,
    input  logic [l2depth-1:0] rd_addr,
    output logic [width-1:0]   d_out
);

    localparam int DEPTH = srl_depth(l2depth);

    logic [width-1:0] dat [DEPTH];

    always_ff @(posedge CLK) begin
        if (shift_en) begin
            dat[0] <= d_in;
            for (int i = 1; i < DEPTH; i++) begin
                dat[i] <= dat[i-1];
            end
        end
    end

    assign d_out = dat[rd_addr];

endmodule

// File: rtl/ar_srl_fifo_reg_cnt.sv
// ---------------------------------------------------------------------------
// ar_srl_fifo_reg_cnt
//   SRL-based FIFO with one registered output stage (D register after the
//   SRL) for Fmax, plus an occupancy counter, programmable almost-full /
//   almost-empty flags, guarded ENQ/DEQ and a synchronous clear.
//   Total capacity CAP = 2**l2depth + 1.
//
//   Handshake: ENQ is taken only while FULL_N=1; DEQ is taken only while
//   EMPTY_N=1. A strobe presented while its guard is low is ignored and
//   changes no state. D_OUT is valid whenever EMPTY_N=1 and advances on the
//   edge where DEQ is taken.
//
//   Optional build macro: AR_SRLFIFO_ERRFLAG_EN adds sticky OVF/UDF outputs.
//
//   Parameters
//     width       data bits per entry
//     l2depth     log2 of SRL depth
//     afull_thr   AFULL when COUNT >= afull_thr   (clamped to 1..CAP)
//     aempty_thr  AEMPTY when COUNT <= aempty_thr (clamped to 0..CAP-1)
//
//   Ports
//     CLK      in   1            clock, posedge
//     RST_N    in   1            synchronous active-low reset
//     CLR      in   1            synchronous clear, same effect as reset
//     ENQ      in   1            enqueue D_IN
//     DEQ      in   1            dequeue D_OUT
//     D_IN     in   width        write data
//     FULL_N   out  1            SRL can accept ENQ this cycle
//     EMPTY_N  out  1            D_OUT holds valid data
//     D_OUT    out  width        head-of-queue data from the D register
//     COUNT    out  l2depth+1    entries held, 0..CAP
//     AFULL    out  1            COUNT >= afull_thr
//     AEMPTY   out  1            COUNT <= aempty_thr
//     OVF      out  1            sticky: ENQ seen while full  (macro only)
//     UDF      out  1            sticky: DEQ seen while empty (macro only)
// ---------------------------------------------------------------------------
module ar_srl_fifo_reg_cnt
    import ar_fifo_pkg::*;
#(
    parameter int width      = 128,
    parameter int l2depth    = 5,
    parameter int afull_thr  = fifo_cap(l2depth) - 2,
    parameter int aempty_thr = 1
) (
    input  logic                      CLK,
    input  logic                      RST_N,
    input  logic                      CLR,
    input  logic                      ENQ,
    input  logic                      DEQ,
    input  logic [width-1:0]          D_IN,
    output logic                      FULL_N,
    output logic                      EMPTY_N,
    output logic [width-1:0]          D_OUT,
    output logic [cnt_w(l2depth)-1:0] COUNT,
    output logic                      AFULL,
    output logic                      AEMPTY
`ifdef AR_SRLFIFO_ERRFLAG_EN
    ,
    output logic                      OVF,
    output logic                      UDF
`endif
);

    localparam int DEPTH    = srl_depth(l2depth);
    localparam int CAP      = fifo_cap(l2depth);
    localparam int PW       = l2depth + 1;
    localparam int CW       = cnt_w(l2depth);
    localparam int AFULL_T  = thr_clamp(afull_thr, 1, CAP);
    localparam int AEMPTY_T = thr_clamp(aempty_thr, 0, CAP - 1);

    // Control state, kept together so a checker can bind to one signal.
    //   pos    : live entries in the SRL (0..DEPTH)
    //   sempty : pos == 0
    //   sfull  : pos == DEPTH
    //   dempty : D register holds no valid word
    typedef struct packed {
        logic [PW-1:0] pos;
        logic          sempty;
        logic          sfull;
        logic          dempty;
    } ctrl_t;

    ctrl_t              ctrl_q;
    ctrl_t              ctrl_d;

    logic               rst;
    logic               enq_eff;
    logic               deq_eff;
    logic               sdx;
    logic [l2depth-1:0] rd_addr;
    logic [width-1:0]   srl_out;
    logic [width-1:0]   d_q;

    logic [CW-1:0]      count_q;
    logic [CW-1:0]      count_d;
    logic               afull_q;
    logic               afull_d;
    logic               aempty_q;
    logic               aempty_d;

    assign rst     = !RST_N || CLR;
    assign enq_eff = ENQ && !ctrl_q.sfull;
    assign deq_eff = DEQ && !ctrl_q.dempty;

    // Move the oldest SRL word into the D register whenever the SRL has one
    // and the D register is, or is about to become, free.
    assign sdx = !ctrl_q.sempty && (ctrl_q.dempty || deq_eff);

    // Oldest live entry is at pos-1. When pos == DEPTH the low bits wrap to
    // zero and the subtraction lands on DEPTH-1, which is the intended entry.
    assign rd_addr = ctrl_q.pos[l2depth-1:0] - l2depth'(1);

    // Shift array. Data shifts on every accepted ENQ regardless of reset so
    // the array stays free of reset logic; control state discards it anyway.
    ar_srl_shift #(
        .width   (width),
        .l2depth (l2depth)
    ) u_srl (
        .CLK      (CLK),
        .shift_en (enq_eff),
        .d_in     (D_IN),
        .rd_addr  (rd_addr),
        .d_out    (srl_out)
    );

    // ---------------- state register ----------------
    always_ff @(posedge CLK) begin
        if (rst) begin
            ctrl_q   <= '{pos: '0, sempty: 1'b1, sfull: 1'b0, dempty: 1'b1};
            count_q  <= '0;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
        end else begin
            ctrl_q   <= ctrl_d;
            count_q  <= count_d;
            afull_q  <= afull_d;
            aempty_q <= aempty_d;
        end
    end

    // Output data register, intentionally without reset.
    always_ff @(posedge CLK) begin
        if (sdx) begin
            d_q <= srl_out;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        ctrl_d = ctrl_q;

        case ({enq_eff, sdx})
            2'b10:   ctrl_d.pos = ctrl_q.pos + PW'(1);
            2'b01:   ctrl_d.pos = ctrl_q.pos - PW'(1);
            default: ctrl_d.pos = ctrl_q.pos;
        endcase

        // Flags are decoded from the current pos and the strobes rather than
        // from the incremented pos, keeping the adder off the flag paths.
        ctrl_d.sempty = ((ctrl_q.pos == PW'(0)) && !enq_eff) ||
                        ((ctrl_q.pos == PW'(1)) && sdx && !enq_eff);
        ctrl_d.sfull  = ((ctrl_q.pos == PW'(DEPTH)) && !sdx) ||
                        ((ctrl_q.pos == PW'(DEPTH - 1)) && enq_eff && !sdx);

        // A transfer refills the D register even when it is dequeued in the
        // same cycle, so sdx wins over deq_eff.
        if (sdx) begin
            ctrl_d.dempty = 1'b0;
        end else if (deq_eff) begin
            ctrl_d.dempty = 1'b1;
        end

        count_d  = count_q + CW'(enq_eff) - CW'(deq_eff);
        afull_d  = (count_d >= CW'(AFULL_T));
        aempty_d = (count_d <= CW'(AEMPTY_T));
    end

    // ---------------- outputs ----------------
    always_comb begin
        FULL_N  = !ctrl_q.sfull;
        EMPTY_N = !ctrl_q.dempty;
        D_OUT   = d_q;
        COUNT   = count_q;
        AFULL   = afull_q;
        AEMPTY  = aempty_q;
    end

`ifdef AR_SRLFIFO_ERRFLAG_EN
    // Sticky protocol-violation flags, cleared only by reset/clear.
    logic ovf_q;
    logic udf_q;

    always_ff @(posedge CLK) begin
        if (rst) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            if (ENQ && ctrl_q.sfull) begin
                ovf_q <= 1'b1;
            end
            if (DEQ && ctrl_q.dempty) begin
                udf_q <= 1'b1;
            end
        end
    end

    assign OVF = ovf_q;
    assign UDF = udf_q;
`endif

endmodule

// File: tb/tb_ar_srl_fifo_reg_cnt.sv
// ---------------------------------------------------------------------------
// tb_ar_srl_fifo_reg_cnt
//   Directed bench for ar_srl_fifo_reg_cnt with width=8, l2depth=2 (CAP=5,
//   afull_thr=3, aempty_thr=1). Data words are pushed to exp_q when an
//   accepted ENQ is driven and popped/compared when DEQ takes the head.
//   Inputs change on the falling edge; outputs are sampled on the falling
//   edge, half a period away from the active edge.
// ---------------------------------------------------------------------------
module tb_ar_srl_fifo_reg_cnt;

    localparam int W   = 8;
    localparam int L2  = 2;
    localparam int CAP = 5;
    localparam int CW  = L2 + 1;

    logic          CLK = 1'b0;
    logic          RST_N;
    logic          CLR;
    logic          ENQ;
    logic          DEQ;
    logic [W-1:0]  D_IN;
    logic          FULL_N;
    logic          EMPTY_N;
    logic [W-1:0]  D_OUT;
    logic [CW-1:0] COUNT;
    logic          AFULL;
    logic          AEMPTY;
`ifdef AR_SRLFIFO_ERRFLAG_EN
    logic          OVF;
    logic          UDF;
`endif

    int n_cmp = 0;
    int n_mis = 0;
    logic [W-1:0] exp_q[$];

    ar_srl_fifo_reg_cnt #(
        .width   (W),
        .l2depth (L2)
    ) dut (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .CLR     (CLR),
        .ENQ     (ENQ),
        .DEQ     (DEQ),
        .D_IN    (D_IN),
        .FULL_N  (FULL_N),
        .EMPTY_N (EMPTY_N),
        .D_OUT   (D_OUT),
        .COUNT   (COUNT),
        .AFULL   (AFULL),
        .AEMPTY  (AEMPTY)
`ifdef AR_SRLFIFO_ERRFLAG_EN
        ,
        .OVF     (OVF),
        .UDF     (UDF)
`endif
    );

    // ---------------- clock ----------------
    always #5 CLK = ~CLK;

    // ---------------- compare ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver ----------------
    // Called on a falling edge. enq_acc / deq_acc state what the bench expects
    // the FIFO to accept this cycle; an accepted DEQ compares the head first.
    task automatic step(input logic enq, input logic enq_acc,
                        input logic deq, input logic deq_acc,
                        input logic [W-1:0] din);
        if (deq_acc) begin
            chk("head_valid", 32'(EMPTY_N), 32'd1);
            chk("sb_has_entry", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                chk("head_data", 32'(D_OUT), 32'(exp_q.pop_front()));
            end
        end
        if (enq_acc) begin
            exp_q.push_back(din);
        end
        ENQ  = enq;
        DEQ  = deq;
        D_IN = din;
        @(posedge CLK);
        @(negedge CLK);
        ENQ = 1'b0;
        DEQ = 1'b0;
    endtask

    task automatic pulse_clr(input logic enq, input logic [W-1:0] din);
        CLR  = 1'b1;
        ENQ  = enq;
        D_IN = din;
        @(posedge CLK);
        @(negedge CLK);
        CLR = 1'b0;
        ENQ = 1'b0;
        exp_q.delete();
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        RST_N = 1'b0;
        CLR   = 1'b0;
        ENQ   = 1'b0;
        DEQ   = 1'b0;
        D_IN  = '0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);

        // Reset state
        chk("rst_full_n",  32'(FULL_N),  32'd1);
        chk("rst_empty_n", 32'(EMPTY_N), 32'd0);
        chk("rst_count",   32'(COUNT),   32'd0);
        chk("rst_afull",   32'(AFULL),   32'd0);
        chk("rst_aempty",  32'(AEMPTY),  32'd1);
`ifdef AR_SRLFIFO_ERRFLAG_EN
        chk("rst_ovf", 32'(OVF), 32'd0);
        chk("rst_udf", 32'(UDF), 32'd0);
`endif
        RST_N = 1'b1;

        // Single word: two-edge fall-through
        step(1'b1, 1'b1, 1'b0, 1'b0, 8'hA5);
        chk("ft_e1_empty_n", 32'(EMPTY_N), 32'd0);
        chk("ft_e1_count",   32'(COUNT),   32'd1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        chk("ft_e2_empty_n", 32'(EMPTY_N), 32'd1);
        chk("ft_e2_d_out",   32'(D_OUT),   32'h0000_00A5);
        chk("ft_e2_count",   32'(COUNT),   32'd1);
        chk("ft_e2_aempty",  32'(AEMPTY),  32'd1);
        step(1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
        chk("ft_drain_empty_n", 32'(EMPTY_N), 32'd0);
        chk("ft_drain_count",   32'(COUNT),   32'd0);

        // Fill to capacity with 0..4
        for (int i = 0; i < CAP; i++) begin
            step(1'b1, 1'b1, 1'b0, 1'b0, W'(i));
            chk("fill_count",  32'(COUNT),  32'(i + 1));
            chk("fill_full_n", 32'(FULL_N), 32'(i < CAP - 1));
            chk("fill_afull",  32'(AFULL),  32'(i + 1 >= 3));
            chk("fill_aempty", 32'(AEMPTY), 32'(i + 1 <= 1));
        end

        // ENQ while full is dropped
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h55);
        chk("ovf_drop_count",  32'(COUNT),  32'd5);
        chk("ovf_drop_full_n", 32'(FULL_N), 32'd0);

        // ENQ & DEQ while full: DEQ honoured, ENQ dropped
        step(1'b1, 1'b0, 1'b1, 1'b1, 8'h77);
        chk("full_both_count",  32'(COUNT),  32'd4);
        chk("full_both_full_n", 32'(FULL_N), 32'd1);
        chk("full_both_afull",  32'(AFULL),  32'd1);

        // Drain the remaining four words, one per cycle
        for (int i = 1; i <= 4; i++) begin
            step(1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
            chk("drain_count", 32'(COUNT), 32'(4 - i));
            chk("drain_afull", 32'(AFULL), 32'(4 - i >= 3));
        end
        chk("drain_empty_n", 32'(EMPTY_N), 32'd0);
        chk("drain_aempty",  32'(AEMPTY),  32'd1);

        // DEQ while empty is ignored
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        chk("udf_ign_count",   32'(COUNT),   32'd0);
        chk("udf_ign_empty_n", 32'(EMPTY_N), 32'd0);
`ifdef AR_SRLFIFO_ERRFLAG_EN
        chk("udf_set", 32'(UDF), 32'd1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        chk("udf_sticky", 32'(UDF), 32'd1);
        chk("ovf_after_full", 32'(OVF), 32'd1);
`endif

        // Only the D register holds data: ENQ & DEQ together empties it and
        // the new word shows up two edges after its ENQ
        step(1'b1, 1'b1, 1'b0, 1'b0, 8'h3C);
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        chk("dreg_loaded", 32'(EMPTY_N), 32'd1);
        step(1'b1, 1'b1, 1'b1, 1'b1, 8'hC3);
        chk("dreg_swap_empty_n", 32'(EMPTY_N), 32'd0);
        chk("dreg_swap_count",   32'(COUNT),   32'd1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        chk("dreg_swap_valid",   32'(EMPTY_N), 32'd1);

        // Bring COUNT to 3, then stream ENQ & DEQ every cycle
        step(1'b1, 1'b1, 1'b0, 1'b0, W'($urandom_range(0, 255)));
        step(1'b1, 1'b1, 1'b0, 1'b0, W'($urandom_range(0, 255)));
        chk("stream_pre_count", 32'(COUNT), 32'd3);
        for (int i = 0; i < 100; i++) begin
            step(1'b1, 1'b1, 1'b1, 1'b1, W'($urandom_range(0, 255)));
            chk("stream_count", 32'(COUNT), 32'd3);
        end
        chk("stream_full_n", 32'(FULL_N), 32'd1);

        // CLR with COUNT=4 and ENQ asserted discards everything
        step(1'b1, 1'b1, 1'b0, 1'b0, 8'h99);
        chk("clr_pre_count", 32'(COUNT), 32'd4);
        pulse_clr(1'b1, 8'hEE);
        chk("clr_count",   32'(COUNT),   32'd0);
        chk("clr_empty_n", 32'(EMPTY_N), 32'd0);
        chk("clr_full_n",  32'(FULL_N),  32'd1);
        chk("clr_afull",   32'(AFULL),   32'd0);
        chk("clr_aempty",  32'(AEMPTY),  32'd1);
`ifdef AR_SRLFIFO_ERRFLAG_EN
        chk("clr_ovf", 32'(OVF), 32'd0);
        chk("clr_udf", 32'(UDF), 32'd0);
`endif

        // FIFO works normally after the clear
        step(1'b1, 1'b1, 1'b0, 1'b0, 8'h5A);
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
        chk("post_clr_count", 32'(COUNT), 32'd0);
        chk("sb_drained", 32'(exp_q.size()), 32'd0);

        // Mid-operation reset behaves like CLR
        step(1'b1, 1'b1, 1'b0, 1'b0, 8'h11);
        step(1'b1, 1'b1, 1'b0, 1'b0, 8'h22);
        RST_N = 1'b0;
        ENQ   = 1'b1;
        D_IN  = 8'h33;
        @(posedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
        ENQ   = 1'b0;
        exp_q.delete();
        chk("rst_mid_count",   32'(COUNT),   32'd0);
        chk("rst_mid_empty_n", 32'(EMPTY_N), 32'd0);

        // ---------------- report ----------------
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
